// File: rtl/mips_pkg.sv
// Shared definitions for the operand-B source selector: default widths,
// debounce length and the IN-handshake FSM state encoding.
package mips_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int IMM_W_DEF      = 16;
   localparam int SW_W_DEF       = 16;
   localparam int DEB_CYCLES_DEF = 50000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      DONE         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a counter debouncer for the confirm
// push-button. dout only changes after DEB_CYCLES consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the count.
module debounce_sync
   import mips_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;

   // Stage p0/p1: bring the asynchronous button into the clock domain
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
      end
   end

   // Accept a new level only after it has persisted for DEB_CYCLES cycles
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (sync_p1 == dout) begin
         cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt  <= '0;
         dout <= sync_p1;
      end else begin
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/operand_src_sel.sv
// ALU operand-B selector: register data, extended immediate, or the latched
// switch bank for the IN instruction. An IN stalls the core until the
// debounced confirm button is pressed, then releases it for one cycle.
// Optional feature macro: OPSRC_SIGN_EXT_EN (sext=1 sign-extends the
// immediate when defined; otherwise the immediate is always zero-extended).
module operand_src_sel
   import mips_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IMM_W      = IMM_W_DEF,
   parameter int SW_W       = SW_W_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              alu_src,
   input  logic              in_op,
   input  logic              sext,
   input  logic [DATA_W-1:0] dado2,
   input  logic [IMM_W-1:0]  imediato,
   input  logic [SW_W-1:0]   interruptores,
   input  logic              confirma,
   output logic [DATA_W-1:0] saida_alusrc,
   output logic              stall
);

`ifdef OPSRC_SIGN_EXT_EN
   function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic sx);
      logic signed [IMM_W-1:0]  imm_s;
      logic signed [DATA_W-1:0] imm_x;
      imm_s = imm;
      imm_x = DATA_W'(imm_s);
      if (sx)
         return imm_x;
      else
         return DATA_W'(imm);
   endfunction
`else
   function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
      return DATA_W'(imm);
   endfunction

   // sext has no effect in a zero-extend-only build
   logic unused_sext;
   assign unused_sext = sext;
`endif

   state_t          state;
   state_t          state_nxt;
   logic            conf_db;
   logic            conf_db_q;
   logic            conf_rise;
   logic            latch_en;
   logic            in_req;
   logic [SW_W-1:0] sw_p0;
   logic [SW_W-1:0] sw_p1;
   logic [SW_W-1:0] sw_reg;

   debounce_sync #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (confirma),
      .dout    (conf_db)
   );

   assign in_req    = alu_src & in_op;
   assign conf_rise = conf_db & ~conf_db_q;

   // Stage p0/p1: synchronize the switch bank before it is latched
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_p0 <= '0;
         sw_p1 <= '0;
      end else begin
         sw_p0 <= interruptores;
         sw_p1 <= sw_p0;
      end
   end

   // FSM state, confirm edge history and the switch latch
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         conf_db_q <= 1'b0;
         sw_reg    <= '0;
      end else begin
         state     <= state_nxt;
         conf_db_q <= conf_db;
         if (latch_en)
            sw_reg <= sw_p1;
      end
   end

   // Next state and stall: a press only counts on a rising edge seen while
   // waiting, so a press held from earlier must be released first
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      latch_en  = 1'b0;
      case (state)
         IDLE: begin
            stall = in_req;
            if (in_req)
               state_nxt = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            stall = 1'b1;
            if (conf_rise) begin
               latch_en  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            stall = in_req;
            if (!conf_db)
               state_nxt = in_req ? WAIT_PRESS : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand-B source multiplexer
   always_comb begin
      saida_alusrc = dado2;
      if (alu_src) begin
         if (in_op)
            saida_alusrc = DATA_W'(sw_reg);
         else
`ifdef OPSRC_SIGN_EXT_EN
            saida_alusrc = ext_imm(imediato, sext);
`else
            saida_alusrc = ext_imm(imediato);
`endif
      end
   end

endmodule

// File: tb/tb_operand_src_sel.sv
// Self-checking bench for operand_src_sel with DEB_CYCLES=4: a vector table
// for the combinational selections and scripted sequences for the IN
// handshake, debounce glitch rejection and asynchronous reset.
module tb_operand_src_sel;
   import mips_pkg::*;

`ifdef OPSRC_SIGN_EXT_EN
   localparam bit SEXT_EN = 1'b1;
`else
   localparam bit SEXT_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        alu_src;
   logic        in_op;
   logic        sext;
   logic [31:0] dado2;
   logic [15:0] imediato;
   logic [15:0] interruptores;
   logic        confirma;
   logic [31:0] saida_alusrc;
   logic        stall;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic        alu_src;
      logic        in_op;
      logic        sext;
      logic [31:0] dado2;
      logic [15:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[8];

   operand_src_sel #(
      .DATA_W     (32),
      .IMM_W      (16),
      .SW_W       (16),
      .DEB_CYCLES (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .alu_src       (alu_src),
      .in_op         (in_op),
      .sext          (sext),
      .dado2         (dado2),
      .imediato      (imediato),
      .interruptores (interruptores),
      .confirma      (confirma),
      .saida_alusrc  (saida_alusrc),
      .stall         (stall)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic hold_stall(input int n, input string nm, input logic exp);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk(nm, {31'd0, stall}, {31'd0, exp});
      end
   endtask

   // Wait for the single stall=0 cycle of DONE and compare against the scoreboard
   task automatic wait_done(input int maxc, input string nm);
      logic [31:0] exp;
      bit found;
      found = 1'b0;
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
      for (int i = 0; i < maxc && !found; i++) begin
         @(negedge clock);
         if (!stall) begin
            found = 1'b1;
            chk(nm, saida_alusrc, exp);
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=stall_high required=done_within_%0d", nm, maxc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 16'h1234, 32'hDEADBEEF};
      vt[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 16'hFFFF, 32'h0000_0000};
      vt[2] = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'h8001, 32'h1234_5678};
      vt[3] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'h8001,
                SEXT_EN ? 32'hFFFF_8001 : 32'h0000_8001};
      vt[4] = '{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 16'h8001, 32'h0000_8001};
      vt[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 16'h7FFF, 32'h0000_7FFF};
      vt[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 16'hFFFF,
                SEXT_EN ? 32'hFFFF_FFFF : 32'h0000_FFFF};
      vt[7] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 16'h0000, 32'h0000_0000};

      reset_n = 1'b0;
      alu_src = 1'b0;
      in_op = 1'b0;
      sext = 1'b0;
      dado2 = 32'h0;
      imediato = 16'h0;
      interruptores = 16'h0;
      confirma = 1'b0;

      // Reset state
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      chk("rst_sw_reg", 32'(dut.sw_reg), 32'd0);
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();

      // Combinational selection table
      for (int i = 0; i < 8; i++) begin
         alu_src = vt[i].alu_src;
         in_op = vt[i].in_op;
         sext = vt[i].sext;
         dado2 = vt[i].dado2;
         imediato = vt[i].imm;
         interruptores = 16'h5555;
         sb.push_back(vt[i].exp);
         #1;
         chk($sformatf("vec%0d_out", i), saida_alusrc, sb.pop_front());
         chk($sformatf("vec%0d_stall", i), {31'd0, stall}, 32'd0);
         cyc();
      end

      // IN with a stable press, then a back-to-back IN on the same held press
      alu_src = 1'b1;
      in_op = 1'b1;
      sext = 1'b0;
      interruptores = 16'h00A5;
      sb.push_back(32'h0000_00A5);
      #1;
      chk("in_req_stall", {31'd0, stall}, 32'd1);
      hold_stall(3, "wait_press_stall", 1'b1);
      cyc();
      confirma = 1'b1;
      wait_done(20, "in_a5");
      cyc();
      interruptores = 16'h003C;
      sb.push_back(32'h0000_003C);
      hold_stall(8, "held_press_stall", 1'b1);
      chk("sw_reg_a5_held", saida_alusrc, 32'h0000_00A5);
      cyc();
      confirma = 1'b0;
      hold_stall(8, "release_stall", 1'b1);
      cyc();
      confirma = 1'b1;
      wait_done(20, "in_3c");
      cyc();
      alu_src = 1'b0;
      in_op = 1'b0;
      #1;
      chk("release_no_req", {31'd0, stall}, 32'd0);
      confirma = 1'b0;
      hold_stall(8, "idle_no_stall", 1'b0);

      // Press made while idle must not satisfy a later IN
      cyc();
      confirma = 1'b1;
      hold_stall(8, "idle_press_nostall", 1'b0);
      cyc();
      alu_src = 1'b1;
      in_op = 1'b1;
      interruptores = 16'h005A;
      sb.push_back(32'h0000_005A);
      hold_stall(10, "idle_press_ignored", 1'b1);
      cyc();
      confirma = 1'b0;
      hold_stall(8, "idle_release_stall", 1'b1);
      cyc();
      confirma = 1'b1;
      wait_done(20, "in_5a");
      cyc();
      alu_src = 1'b0;
      in_op = 1'b0;
      confirma = 1'b0;
      hold_stall(8, "after_5a_idle", 1'b0);

      // Three-cycle glitch during WAIT_PRESS is rejected
      cyc();
      alu_src = 1'b1;
      in_op = 1'b1;
      interruptores = 16'h0077;
      hold_stall(2, "glitch_pre_stall", 1'b1);
      cyc();
      confirma = 1'b1;
      cyc();
      cyc();
      cyc();
      confirma = 1'b0;
      hold_stall(10, "glitch_stall", 1'b1);
      chk("glitch_no_latch", saida_alusrc, 32'h0000_005A);

      // Asynchronous reset in WAIT_PRESS abandons the pending IN
      cyc();
      alu_src = 1'b0;
      in_op = 1'b0;
      #1;
      chk("wait_press_no_req", {31'd0, stall}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_stall", {31'd0, stall}, 32'd0);
      chk("arst_state", 32'(dut.state), 32'(IDLE));
      chk("arst_sw_reg", 32'(dut.sw_reg), 32'd0);
      alu_src = 1'b1;
      in_op = 1'b1;
      #1;
      chk("arst_sw_out", saida_alusrc, 32'h0);
      alu_src = 1'b0;
      in_op = 1'b0;
      cyc();
      reset_n = 1'b1;
      hold_stall(4, "post_rst_idle", 1'b0);
      chk("post_rst_state", 32'(dut.state), 32'(IDLE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_src_sel.md
OPERAND_SRC_SEL -- requirements
Module: operand_src_sel

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: operand and output width.
REQ-002 SHALL provide parameter IMM_W, default 16: immediate width, 1 < IMM_W <= DATA_W.
REQ-003 SHALL provide parameter SW_W, default 16: switch-bank width, SW_W <= DATA_W.
REQ-004 SHALL provide parameter DEB_CYCLES, default 50000: stable cycles required before a confirm-button change is accepted, >= 2.
REQ-005 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port alu_src, input, 1: 1 selects a non-register operand.
REQ-008 SHALL have port in_op, input, 1: with alu_src=1, selects the switch operand (IN instruction).
REQ-009 SHALL have port sext, input, 1: 1 requests sign extension of the immediate.
REQ-010 SHALL have port dado2, input, DATA_W: register-file read data 2.
REQ-011 SHALL have port imediato, input, IMM_W: instruction immediate.
REQ-012 SHALL have port interruptores, input, SW_W: asynchronous board switches.
REQ-013 SHALL have port confirma, input, 1: asynchronous, bouncing confirm push-button, high = pressed.
REQ-014 SHALL have port saida_alusrc, output, DATA_W: ALU operand B.
REQ-015 SHALL have port stall, output, 1: high freezes the PC and register write while an IN waits.

Function
REQ-016 SHALL drive saida_alusrc = dado2 combinationally when alu_src=0.
REQ-017 SHALL drive the extended imediato combinationally when alu_src=1 and in_op=0: zero-extended, or sign-extended when sext=1 and sign extension is compiled in.
REQ-018 SHALL drive {zeros, sw_reg} when alu_src=1 and in_op=1, where sw_reg is the latched switch value.
REQ-019 SHALL pass confirma through a 2-flop synchronizer, then a debouncer that updates conf_db only after DEB_CYCLES consecutive cycles of a synchronized value differing from conf_db; any agreeing cycle clears the counter.
REQ-020 SHALL implement FSM states IDLE, WAIT_PRESS, DONE, WAIT_RELEASE.
REQ-021 SHALL move IDLE -> WAIT_PRESS when alu_src & in_op; stall=1 in that same cycle (combinational from the request).
REQ-022 SHALL keep stall=1 in WAIT_PRESS; on a conf_db rising edge, latch synchronized interruptores into sw_reg and go to DONE.
REQ-023 SHALL hold stall=0 for exactly one cycle in DONE so the IN instruction retires with the new sw_reg, then go to WAIT_RELEASE.
REQ-024 SHALL return WAIT_RELEASE -> IDLE once conf_db=0; an IN request in WAIT_RELEASE keeps stall=1, and on release goes directly to WAIT_PRESS, so one press satisfies exactly one IN.
REQ-025 SHALL keep stall=0 in IDLE and WAIT_RELEASE when no IN request is present; non-IN selections never stall.
REQ-026 SHALL ignore a confirm press that occurs in IDLE: no latch, and the press must be released before it can satisfy a later IN.

Reset
REQ-027 SHALL on reset_n=0 immediately force state=IDLE, sw_reg=0, conf_db=0, debounce counter=0, synchronizer flops=0, and stall=0 absent a request; an IN pending at reset is abandoned.

Configuration
REQ-028 SHALL honour macro OPSRC_SIGN_EXT_EN: when defined, sext=1 sign-extends imediato; when undefined, sext is ignored and the immediate is always zero-extended.

Structure
REQ-029 SHALL place the FSM state enum and default width constants in shared package mips_pkg.
REQ-030 SHALL implement the synchronizer and debouncer as sub-module debounce_sync, instantiated once.

Verification (DEB_CYCLES=4)
REQ-031 SHALL check alu_src=0, dado2=0xDEADBEEF -> saida_alusrc=0xDEADBEEF, stall=0, same cycle.
REQ-032 SHALL check alu_src=1, in_op=0, imediato=0x8001, sext=1 -> 0xFFFF8001 with the macro, 0x00008001 without it.
REQ-033 SHALL check IN with interruptores=0x00A5 and a stable press: stall=1 until DONE, then one stall=0 cycle with saida_alusrc=0x000000A5.
REQ-034 SHALL check a 3-cycle glitch on confirma during WAIT_PRESS -> no latch, stall stays 1.
REQ-035 SHALL check two back-to-back INs with one held press -> second IN stalls until release and a new press.
REQ-036 SHALL check reset_n pulsed low in WAIT_PRESS -> state=IDLE, sw_reg=0, stall=0 asynchronously.
